// File: rtl/vram_pkg.sv
// Shared VRAM responder types: address/data widths, FSM states and arbiter grant codes.
package vram_pkg;

    localparam int VRAM_ADDR_W = 21;
    localparam int VRAM_PAGE_W = 8;
    localparam int VRAM_DATA_W = 8;
    localparam int VID_ADDR_W  = VRAM_ADDR_W - VRAM_PAGE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VID_RD,
        ST_VID_WAIT,
        ST_VID_ACK,
        ST_CPU_RD,
        ST_CPU_WAIT,
        ST_CPU_WR,
        ST_CPU_ACK
    } vram_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU_RD,
        GNT_CPU_WR
    } vram_grant_e;

endpackage

// File: rtl/vram_arb.sv
// Combinational VRAM grant: video over CPU, write over read. With VRAM_RESP_FAIRNESS_EN,
// a run counter forces a CPU grant after MAX_VID_RUN video grants made while the CPU waits.
module vram_arb
    import vram_pkg::*;
`ifdef VRAM_RESP_FAIRNESS_EN
#(
    parameter int MAX_VID_RUN = 4
)
`endif
(
`ifdef VRAM_RESP_FAIRNESS_EN
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        grant_en,
`endif
    input  logic        vid_rd_req,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output vram_grant_e grant
);

    logic cpu_pend;
    logic force_cpu;

    assign cpu_pend = cpu_we | cpu_re;

`ifdef VRAM_RESP_FAIRNESS_EN
    localparam int CW = $clog2(MAX_VID_RUN + 1);

    logic [CW-1:0] vid_run;

    assign force_cpu = (vid_run >= CW'(MAX_VID_RUN));

    // Only video grants that actually overtake a waiting CPU count toward the run.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_run <= '0;
        end else if (!cpu_pend) begin
            vid_run <= '0;
        end else if (grant_en) begin
            if (grant == GNT_VID) begin
                vid_run <= vid_run + CW'(1);
            end else if (grant == GNT_CPU_RD || grant == GNT_CPU_WR) begin
                vid_run <= '0;
            end
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        grant = GNT_NONE;
        if (cpu_pend && force_cpu) begin
            grant = cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
        end else if (vid_rd_req) begin
            grant = GNT_VID;
        end else if (cpu_we) begin
            grant = GNT_CPU_WR;
        end else if (cpu_re) begin
            grant = GNT_CPU_RD;
        end
    end

endmodule

// File: rtl/vram_responder.sv
// Shared VRAM responder for video fetch and CPU accesses, one access in flight.
// Optional CPU fairness under VRAM_RESP_FAIRNESS_EN (see vram_arb).
module vram_responder
    import vram_pkg::*;
#(
    parameter int RD_LATENCY  = 1,
    parameter int MAX_VID_RUN = 4
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [VID_ADDR_W-1:0]  vid_addr,
    input  logic [VRAM_PAGE_W-1:0] vid_page,
    input  logic                   vid_rd_req,
    output logic                   vid_rd_ack,
    output logic [VRAM_DATA_W-1:0] vid_data,
    input  logic [VRAM_ADDR_W-1:0] cpu_addr,
    input  logic [VRAM_DATA_W-1:0] cpu_wdata,
    input  logic                   cpu_we,
    input  logic                   cpu_re,
    output logic [VRAM_DATA_W-1:0] cpu_rdata,
    output logic                   cpu_ready,
    output logic [VRAM_ADDR_W-1:0] mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [VRAM_DATA_W-1:0] mem_wdata,
    input  logic [VRAM_DATA_W-1:0] mem_rdata
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 3 || MAX_VID_RUN < 1) begin : g_bad_cfg
            $error("vram_responder: RD_LATENCY must be 1..3 and MAX_VID_RUN >= 1");
        end
    endgenerate

    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    vram_state_e state;
    vram_grant_e grant;
    logic [1:0]  lat_cnt;

    vram_arb
`ifdef VRAM_RESP_FAIRNESS_EN
        #(.MAX_VID_RUN(MAX_VID_RUN))
`endif
        u_arb (
`ifdef VRAM_RESP_FAIRNESS_EN
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .grant_en   (state == ST_IDLE),
`endif
        .vid_rd_req (vid_rd_req),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .grant      (grant)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            vid_rd_ack <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Address and data are frozen here; inputs may change freely afterwards.
                    case (grant)
                        GNT_VID: begin
                            mem_addr <= {vid_page, vid_addr};
                            mem_rd   <= 1'b1;
                            state    <= ST_VID_RD;
                        end
                        GNT_CPU_RD: begin
                            mem_addr <= cpu_addr;
                            mem_rd   <= 1'b1;
                            state    <= ST_CPU_RD;
                        end
                        GNT_CPU_WR: begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_wr    <= 1'b1;
                            state     <= ST_CPU_WR;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_VID_RD: begin
                    mem_rd  <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_VID_WAIT;
                end
                ST_VID_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        vid_data   <= mem_rdata;
                        vid_rd_ack <= 1'b1;
                        state      <= ST_VID_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_VID_ACK: begin
                    vid_rd_ack <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_CPU_RD: begin
                    mem_rd  <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_CPU_WAIT;
                end
                ST_CPU_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        state     <= ST_CPU_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_CPU_WR: begin
                    mem_wr    <= 1'b0;
                    cpu_ready <= 1'b1;
                    state     <= ST_CPU_ACK;
                end
                ST_CPU_ACK: begin
                    cpu_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_responder.sv
// Scoreboard bench for vram_responder: DUT 0 at RD_LATENCY=1, DUT 1 at RD_LATENCY=3.
// Fairness expectations follow VRAM_RESP_FAIRNESS_EN.
module tb_vram_responder;

    localparam int CLS_MEM = 0;
    localparam int CLS_VID = 1;
    localparam int CLS_CPU = 2;
    localparam int K_RD    = 1;
    localparam int K_WR    = 2;

    typedef struct {
        int          dut;
        int          cls;
        int          kind;
        logic [20:0] addr;
        logic [7:0]  data;
        bit          chk_data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [12:0] vid_addr   [2];
    logic [7:0]  vid_page   [2];
    logic        vid_rd_req [2];
    logic        vid_rd_ack [2];
    logic [7:0]  vid_data   [2];
    logic [20:0] cpu_addr   [2];
    logic [7:0]  cpu_wdata  [2];
    logic        cpu_we     [2];
    logic        cpu_re     [2];
    logic [7:0]  cpu_rdata  [2];
    logic        cpu_ready  [2];
    logic [20:0] mem_addr   [2];
    logic        mem_rd     [2];
    logic        mem_wr     [2];
    logic [7:0]  mem_wdata  [2];
    logic [7:0]  mem_rdata  [2];

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    logic [7:0] vram [logic [20:0]];
    logic [2:0] pv0 = '0;
    logic [2:0] pv1 = '0;
    logic [7:0] pd0 [3];
    logic [7:0] pd1 [3];

    vram_responder #(.RD_LATENCY(1), .MAX_VID_RUN(4)) dut0 (
        .vga_clk(clk), .reset_n(reset_n),
        .vid_addr(vid_addr[0]), .vid_page(vid_page[0]), .vid_rd_req(vid_rd_req[0]),
        .vid_rd_ack(vid_rd_ack[0]), .vid_data(vid_data[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_we(cpu_we[0]), .cpu_re(cpu_re[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_ready(cpu_ready[0]),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    vram_responder #(.RD_LATENCY(3), .MAX_VID_RUN(4)) dut1 (
        .vga_clk(clk), .reset_n(reset_n),
        .vid_addr(vid_addr[1]), .vid_page(vid_page[1]), .vid_rd_req(vid_rd_req[1]),
        .vid_rd_ack(vid_rd_ack[1]), .vid_data(vid_data[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_we(cpu_we[1]), .cpu_re(cpu_re[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_ready(cpu_ready[1]),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] vram_rd(logic [20:0] a);
        return vram.exists(a) ? vram[a] : 8'h99;
    endfunction

    // VRAM models: data is driven only in the cycle it is valid, 8'hEE otherwise.
    always @(posedge clk) begin
        pv0    <= {pv0[1:0], mem_rd[0]};
        pd0[2] <= pd0[1];
        pd0[1] <= pd0[0];
        pd0[0] <= vram_rd(mem_addr[0]);
        pv1    <= {pv1[1:0], mem_rd[1]};
        pd1[2] <= pd1[1];
        pd1[1] <= pd1[0];
        pd1[0] <= vram_rd(mem_addr[1]);
        if (mem_wr[0]) vram[mem_addr[0]] = mem_wdata[0];
        if (mem_wr[1]) vram[mem_addr[1]] = mem_wdata[1];
    end

    assign mem_rdata[0] = pv0[0] ? pd0[0] : 8'hEE;
    assign mem_rdata[1] = pv1[2] ? pd1[2] : 8'hEE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic int find_exp(int d, int c);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].dut == d && exp_q[i].cls == c) return i;
        return -1;
    endfunction

    task automatic push(input int d, input int c, input int k, input logic [20:0] a,
                        input logic [7:0] v, input bit chk, input int at);
        exp_t e;
        e.dut = d; e.cls = c; e.kind = k; e.addr = a; e.data = v; e.chk_data = chk; e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the oldest expectation of the matching class whenever a DUT responds.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   idx;
            exp_t e;
            if (mem_rd[d] || mem_wr[d]) begin
                check($sformatf("d%0d_strobe_excl", d), 64'(mem_rd[d] & mem_wr[d]), 64'd0);
                idx = find_exp(d, CLS_MEM);
                if (idx < 0) begin
                    check($sformatf("d%0d_unexpected_mem", d), 64'd1, 64'd0);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    check($sformatf("d%0d_mem_kind", d), 64'(mem_wr[d] ? K_WR : K_RD), 64'(e.kind));
                    check($sformatf("d%0d_mem_addr", d), 64'(mem_addr[d]), 64'(e.addr));
                    if (e.kind == K_WR)
                        check($sformatf("d%0d_mem_wdata", d), 64'(mem_wdata[d]), 64'(e.data));
                    check($sformatf("d%0d_mem_cycle", d), 64'(cyc), 64'(e.cyc));
                end
            end
            if (vid_rd_ack[d] && cpu_ready[d])
                check($sformatf("d%0d_two_acks", d), 64'd1, 64'd0);
            if (vid_rd_ack[d]) begin
                idx = find_exp(d, CLS_VID);
                if (idx < 0) begin
                    check($sformatf("d%0d_unexpected_vid_ack", d), 64'd1, 64'd0);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    check($sformatf("d%0d_vid_data", d), 64'(vid_data[d]), 64'(e.data));
                    check($sformatf("d%0d_vid_ack_cycle", d), 64'(cyc), 64'(e.cyc));
                end
            end
            if (cpu_ready[d]) begin
                idx = find_exp(d, CLS_CPU);
                if (idx < 0) begin
                    check($sformatf("d%0d_unexpected_cpu_ready", d), 64'd1, 64'd0);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    if (e.chk_data)
                        check($sformatf("d%0d_cpu_rdata", d), 64'(cpu_rdata[d]), 64'(e.data));
                    check($sformatf("d%0d_cpu_ready_cycle", d), 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs(int d);
        return 64'({vid_rd_ack[d], vid_data[d], cpu_rdata[d], cpu_ready[d],
                    mem_addr[d], mem_rd[d], mem_wr[d], mem_wdata[d]});
    endfunction

    initial begin
        int c0;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vid_addr[d] = '0; vid_page[d] = '0; vid_rd_req[d] = 1'b0;
            cpu_addr[d] = '0; cpu_wdata[d] = '0; cpu_we[d] = 1'b0; cpu_re[d] = 1'b0;
        end
        vram[21'h024401] = 8'h41;
        vram[21'h024208] = 8'h72;
        vram[21'h000100] = 8'h3C;
        vram[21'h000010] = 8'hC3;

        tick(2);
        check("d0_reset_outputs", outs(0), 64'd0);
        check("d1_reset_outputs", outs(1), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Single video read
        c0 = cyc;
        vid_page[0] = 8'h12; vid_addr[0] = 13'h0401; vid_rd_req[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        push(0, CLS_VID, 0, 21'h0, 8'h41, 1, c0 + 3);
        tick(3);
        vid_rd_req[0] = 1'b0;
        tick(3);
        check("single_read_drained", 64'(exp_q.size()), 64'd0);

        // Chained reads, address updated on the ack
        c0 = cyc;
        vid_addr[0] = 13'h0401; vid_rd_req[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        push(0, CLS_VID, 0, 21'h0, 8'h41, 1, c0 + 3);
        push(0, CLS_MEM, K_RD, 21'h024208, 8'h00, 0, c0 + 5);
        push(0, CLS_VID, 0, 21'h0, 8'h72, 1, c0 + 7);
        tick(3);
        vid_addr[0] = 13'h0208;
        tick(4);
        vid_rd_req[0] = 1'b0;
        tick(3);
        check("chained_read_drained", 64'(exp_q.size()), 64'd0);

        // Video beats a simultaneous CPU write to the all-ones address
        c0 = cyc;
        vid_addr[0] = 13'h0401; vid_rd_req[0] = 1'b1;
        cpu_addr[0] = 21'h1FFFFF; cpu_wdata[0] = 8'hA5; cpu_we[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        push(0, CLS_VID, 0, 21'h0, 8'h41, 1, c0 + 3);
        push(0, CLS_MEM, K_WR, 21'h1FFFFF, 8'hA5, 0, c0 + 5);
        push(0, CLS_CPU, 0, 21'h0, 8'h00, 0, c0 + 6);
        tick(3);
        vid_rd_req[0] = 1'b0;
        tick(3);
        cpu_we[0] = 1'b0;
        tick(3);
        c0 = cyc;
        cpu_re[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h1FFFFF, 8'h00, 0, c0 + 1);
        push(0, CLS_CPU, 0, 21'h0, 8'hA5, 1, c0 + 3);
        tick(3);
        cpu_re[0] = 1'b0;
        tick(3);
        check("priority_wr_rd_drained", 64'(exp_q.size()), 64'd0);

        // Streaming video with a pending CPU read
        c0 = cyc;
        vid_page[0] = 8'h00; vid_addr[0] = 13'h0100; vid_rd_req[0] = 1'b1;
        cpu_addr[0] = 21'h000010; cpu_re[0] = 1'b1;
`ifdef VRAM_RESP_FAIRNESS_EN
        for (int k = 0; k < 4; k++) begin
            push(0, CLS_MEM, K_RD, 21'h000100, 8'h00, 0, c0 + 1 + 4 * k);
            push(0, CLS_VID, 0, 21'h0, 8'h3C, 1, c0 + 3 + 4 * k);
        end
        push(0, CLS_MEM, K_RD, 21'h000010, 8'h00, 0, c0 + 17);
        push(0, CLS_CPU, 0, 21'h0, 8'hC3, 1, c0 + 19);
`else
        for (int k = 0; k < 5; k++) begin
            push(0, CLS_MEM, K_RD, 21'h000100, 8'h00, 0, c0 + 1 + 4 * k);
            push(0, CLS_VID, 0, 21'h0, 8'h3C, 1, c0 + 3 + 4 * k);
        end
`endif
        tick(19);
        vid_rd_req[0] = 1'b0;
        cpu_re[0] = 1'b0;
        tick(4);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a video read
        c0 = cyc;
        vid_page[0] = 8'h12; vid_addr[0] = 13'h0401; vid_rd_req[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        tick(2);
        reset_n = 1'b0;
        #1;
        check("d0_outputs_in_reset", outs(0), 64'd0);
        vid_rd_req[0] = 1'b0;
        #2;
        reset_n = 1'b1;
        tick(5);
        check("reset_abort_drained", 64'(exp_q.size()), 64'd0);
        c0 = cyc;
        vid_rd_req[0] = 1'b1;
        push(0, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        push(0, CLS_VID, 0, 21'h0, 8'h41, 1, c0 + 3);
        tick(3);
        vid_rd_req[0] = 1'b0;
        tick(3);
        check("post_reset_drained", 64'(exp_q.size()), 64'd0);

        // RD_LATENCY=3: video read, we+re treated as write, read-back
        c0 = cyc;
        vid_page[1] = 8'h12; vid_addr[1] = 13'h0401; vid_rd_req[1] = 1'b1;
        push(1, CLS_MEM, K_RD, 21'h024401, 8'h00, 0, c0 + 1);
        push(1, CLS_VID, 0, 21'h0, 8'h41, 1, c0 + 5);
        tick(5);
        vid_rd_req[1] = 1'b0;
        tick(3);
        c0 = cyc;
        cpu_addr[1] = 21'h0ABCDE; cpu_wdata[1] = 8'h5C; cpu_we[1] = 1'b1; cpu_re[1] = 1'b1;
        push(1, CLS_MEM, K_WR, 21'h0ABCDE, 8'h5C, 0, c0 + 1);
        push(1, CLS_CPU, 0, 21'h0, 8'h00, 0, c0 + 2);
        tick(2);
        cpu_we[1] = 1'b0; cpu_re[1] = 1'b0;
        tick(3);
        c0 = cyc;
        cpu_re[1] = 1'b1;
        push(1, CLS_MEM, K_RD, 21'h0ABCDE, 8'h00, 0, c0 + 1);
        push(1, CLS_CPU, 0, 21'h0, 8'h5C, 1, c0 + 5);
        tick(5);
        cpu_re[1] = 1'b0;
        tick(3);
        check("lat3_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
